// File: rtl/spi_master.sv
// SPI mode-0 initiator: 16-bit frame {addr, rw, data}, MSB first, with the CS setup/hold
// and SCLK half-period timed by a single reloading down-counter.
module spi_master #(
  parameter int SCLK_HALF = 8,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int MAX_SU_HD = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_CNT   = (SCLK_HALF > MAX_SU_HD) ? SCLK_HALF : MAX_SU_HD;
  localparam int CW        = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] LD_HALF  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bitcnt;
  // Bit 15 of the frame goes straight to mosi_pin at start, so only the remaining 15 are kept.
  logic [14:0]   sh;
  logic [7:0]    rx;
  logic          rw_q;
  logic          cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? '0 : cnt - 1'b1;
    case (state)
      IDLE: if (start) begin
        state_nxt = SETUP;
        cnt_nxt   = LD_SETUP;
      end
      SETUP: if (cnt_zero) begin
        state_nxt = LOW;
        cnt_nxt   = LD_HALF;
      end
      LOW: if (cnt_zero) begin
        state_nxt = HIGH;
        cnt_nxt   = LD_HALF;
      end
      HIGH: if (cnt_zero) begin
        if (bitcnt == 4'd15) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          state_nxt = LOW;
          cnt_nxt   = LD_HALF;
        end
      end
      HOLD: if (cnt_zero) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
      bitcnt   <= 4'd0;
      sh       <= '0;
      rx       <= 8'h00;
      rw_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh       <= {addr[5:0], rw, wdata};
          rw_q     <= rw;
          bitcnt   <= 4'd0;
          cs_pin   <= 1'b0;
          mosi_pin <= addr[6];
          busy     <= 1'b1;
        end
        LOW: if (cnt_zero) begin
          sclk_pin <= 1'b1;
          if (rw_q && bitcnt[3]) rx <= {rx[6:0], miso_pin};
        end
        HIGH: if (cnt_zero) begin
          sclk_pin <= 1'b0;
          if (bitcnt != 4'd15) begin
            bitcnt   <= bitcnt + 4'd1;
            mosi_pin <= sh[14];
            sh       <= {sh[13:0], 1'b0};
          end else begin
            mosi_pin <= 1'b0;
          end
        end
        HOLD: if (cnt_zero) cs_pin <= 1'b1;
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (rw_q) rdata <= rx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized transactions against a frame-level reference model of the SPI initiator.
module tb_spi_master;

  localparam int SH  = 4;
  localparam int SU  = 2;
  localparam int HD  = 2;
  localparam int LAT = SU + 32 * SH + HD + 1;

  logic       clk = 1'b0;
  logic       rst_n, start, rw, miso;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, sclk, cs, mosi;
  logic [7:0] rdata;

  spi_master #(.SCLK_HALF(SH), .CS_SETUP(SU), .CS_HOLD(HD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk), .cs_pin(cs),
    .mosi_pin(mosi), .miso_pin(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Pin monitor and slave model, evaluated mid-cycle on the falling clock edge.
  int          rises, falls, dones, done_cyc, cs_fall_cyc, cs_rise_cyc, viol;
  logic [15:0] mosi_bits;
  logic [7:0]  slave_byte;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [7:0]  rdata_model;

  always @(negedge clk) begin
    if (sclk && !p_sclk) begin
      rises++;
      mosi_bits = {mosi_bits[14:0], mosi};
    end
    if (!sclk && p_sclk) begin
      falls++;
      if (falls >= 8 && falls < 16) miso = slave_byte[15 - falls];
      else miso = 1'b0;
    end
    if (sclk && (mosi !== p_mosi || cs !== p_cs)) viol++;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (!cs && p_cs) cs_fall_cyc = cyc;
    if (cs && !p_cs) cs_rise_cyc = cyc;
    p_sclk = sclk;
    p_cs   = cs;
    p_mosi = mosi;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rises = 0; falls = 0; dones = 0; done_cyc = 0; mosi_bits = 16'h0;
    cs_fall_cyc = 0; cs_rise_cyc = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic [7:0] sb, input int pulses, input string tag);
    int t0;
    clear_mon();
    slave_byte = sb;
    rw = r; addr = a; wdata = w; start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    check({tag, "_busy"}, busy, 1'b1);
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    for (int p = 0; p < pulses; p++) begin
      repeat ($urandom_range(3, 20)) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_dones(1, 400);
    check({tag, "_done_seen"}, dones, 1);
    check({tag, "_latency"}, done_cyc - t0, LAT);
    repeat (6) tick();
    if (r) rdata_model = sb;
    check({tag, "_one_done"}, dones, 1);
    check({tag, "_rises"}, rises, 16);
    check({tag, "_falls"}, falls, 16);
    check({tag, "_mosi_frame"}, mosi_bits, {a, r, w});
    check({tag, "_rdata"}, rdata, rdata_model);
    check({tag, "_idle"}, {busy, cs, sclk}, 3'b010);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d1, r1;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
    slave_byte = 8'h00; rdata_model = 8'h00; viol = 0;
    clear_mon();
    repeat (3) tick();
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    tick();

    do_txn(1'b0, 7'h15, 8'hA5, 8'hC3, 0, "write");
    do_txn(1'b1, 7'h7F, 8'h00, 8'h3C, 0, "read");
    do_txn(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 3, "start_while_busy");

    // Reset in the middle of the bit phase.
    clear_mon();
    slave_byte = 8'h5A;
    rw = 1'b1; addr = 7'h2B; wdata = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rises < 5 && n < 200) begin
      tick();
      n++;
    end
    check("midrst_reached_rise5", rises, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", cs, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rdata_model = 8'h00;
    repeat (2) tick();
    check("midrst_no_done", dones, 0);
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, 7'h33, 8'h96, 8'hFF, 0, "after_rst");

    // Back-to-back with start held high.
    clear_mon();
    slave_byte = 8'($urandom);
    rw = 1'b0; addr = 7'h4C; wdata = 8'hE1; start = 1'b1;
    wait_dones(1, 400);
    check("b2b_first_done", dones, 1);
    d1 = done_cyc;
    r1 = cs_rise_cyc;
    n = 0;
    while (cs !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("b2b_cs_high_gap", cs_fall_cyc - r1, 2);
    check("b2b_done_before_refall", (cs_fall_cyc > d1) ? 1 : 0, 1);
    wait_dones(2, 400);
    check("b2b_second_latency", done_cyc - cs_fall_cyc, LAT);
    check("b2b_rises", rises, 32);
    check("b2b_second_frame", mosi_bits, {7'h4C, 1'b0, 8'hE1});
    check("b2b_rdata", rdata, rdata_model);
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2), "random");
    end

    check("no_pin_change_while_sclk_high", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
